// File: rtl/clk_div_arb_pkg.sv
// Shared types and default widths for the two-requester clock-divider arbiter.
package clk_div_arb_pkg;
  localparam int N_REQ     = 2;
  localparam int DIV_W_DEF = 9;
  localparam int DUR_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/clk_div_core.sv
// Divider datapath: phase counter, remaining-toggle register and the divided clock.
module clk_div_core
  import clk_div_arb_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int DUR_W = DUR_W_DEF
) (
  input  logic             clk_20k,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [DUR_W:0]   tog_i,
  output logic             tc_o,
  output logic             clk_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DUR_W:0]   tog_q, tog_d;
  logic             clk_q, clk_d;

  always_ff @(posedge clk_20k or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tog_q <= '0;
      clk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tog_q <= tog_d;
      clk_q <= clk_d;
    end
  end

  // Clear wins over load, load wins over run.
  always_comb begin
    cnt_d = cnt_q;
    tog_d = tog_q;
    clk_d = clk_q;
    if (clr_i) begin
      cnt_d = '0;
      tog_d = '0;
      clk_d = 1'b0;
    end else if (load_i) begin
      cnt_d = '0;
      tog_d = tog_i;
      clk_d = 1'b0;
    end else if (en_i) begin
      cnt_d = (cnt_q == div_i) ? '0 : cnt_q + DIV_W'(1);
      if (cnt_q == '0 && tog_q != '0) begin
        clk_d = ~clk_q;
        tog_d = tog_q - (DUR_W+1)'(1);
      end
    end
  end

  assign tc_o  = (cnt_q == '0) && (tog_q == '0);
  assign clk_o = clk_q;

endmodule

// File: rtl/clk_div_arbiter.sv
// Arbitrates two requesters onto one programmable divider and reports completion.
// Optional macro CLK_DIV_ARB_ROUND_ROBIN_EN replaces fixed priority with a last-grant pointer.
module clk_div_arbiter
  import clk_div_arb_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int DUR_W = DUR_W_DEF
) (
  input  logic             clk_20k,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [DIV_W-1:0] div0,
  input  logic [DUR_W-1:0] dur0,
  input  logic [DIV_W-1:0] div1,
  input  logic [DUR_W-1:0] dur1,
  output logic [N_REQ-1:0] gnt,
  output logic [N_REQ-1:0] done,
  output logic             busy,
  output logic             clk_out
);

  state_e           state_q, state_d;
  logic             win_q, win_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             win_sel;
  logic [DIV_W-1:0] sel_div;
  logic [DUR_W-1:0] sel_dur;
  logic             core_load, core_en, core_clr, core_tc;
  logic [N_REQ-1:0] win_vec;

`ifdef CLK_DIV_ARB_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;

  always_ff @(posedge clk_20k or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

  assign ptr_d   = core_load ? win_sel : ptr_q;
  assign win_sel = (req == 2'b11) ? ~ptr_q : ~req[0];
`else
  assign win_sel = ~req[0];
`endif

  assign sel_div = win_sel ? div1 : div0;
  assign sel_dur = win_sel ? dur1 : dur0;

  always_ff @(posedge clk_20k or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      win_q   <= 1'b0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      div_q   <= div_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    div_d     = div_q;
    core_load = 1'b0;
    core_en   = 1'b0;
    core_clr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d   = ST_RUN;
          win_d     = win_sel;
          div_d     = (sel_div == '0) ? DIV_W'(1) : sel_div;
          core_load = 1'b1;
        end
      end
      ST_RUN: begin
        core_en = 1'b1;
        // A dropped grant aborts silently; terminal count leads to the done pulse.
        if (!req[win_q]) begin
          state_d  = ST_IDLE;
          core_clr = 1'b1;
        end else if (core_tc) begin
          state_d  = ST_DONE;
          core_clr = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        state_d  = ST_IDLE;
        core_clr = 1'b1;
      end
    endcase
  end

  clk_div_core #(
    .DIV_W (DIV_W),
    .DUR_W (DUR_W)
  ) u_core (
    .clk_20k (clk_20k),
    .rst_n   (rst_n),
    .load_i  (core_load),
    .en_i    (core_en),
    .clr_i   (core_clr),
    .div_i   (div_q),
    .tog_i   ({sel_dur, 1'b0}),
    .tc_o    (core_tc),
    .clk_o   (clk_out)
  );

  assign win_vec = {win_q, ~win_q};
  assign gnt     = (state_q != ST_IDLE) ? win_vec : '0;
  assign done    = (state_q == ST_DONE) ? win_vec : '0;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_clk_div_arbiter.sv
// Randomized and directed bench for clk_div_arbiter against a timeline-based reference model.
module tb_clk_div_arbiter;
  import clk_div_arb_pkg::*;

  logic        clk_20k = 1'b0;
  logic        rst_n   = 1'b0;
  logic [1:0]  req     = '0;
  logic [8:0]  div0 = '0, div1 = '0;
  logic [15:0] dur0 = '0, dur1 = '0;
  logic [1:0]  gnt, done;
  logic        busy, clk_out;

  int n_checks = 0;
  int n_errors = 0;

  // Model: transaction timeline (mode 0 idle, 1 run, 2 done) with RUN length and cycle index.
  int m_mode = 0;
  int m_win  = 0;
  int m_r    = 0;
  int m_len  = 0;
  int m_h    = 1;
  int m_ptr  = 0;

  always #5 clk_20k = ~clk_20k;

  clk_div_arbiter #(.DIV_W(9), .DUR_W(16)) dut (
    .clk_20k (clk_20k),
    .rst_n   (rst_n),
    .req     (req),
    .div0    (div0),
    .dur0    (dur0),
    .div1    (div1),
    .dur1    (dur1),
    .gnt     (gnt),
    .done    (done),
    .busy    (busy),
    .clk_out (clk_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] onehot(input int w);
    return (w == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_r    = 0;
    m_ptr  = 0;
  endtask

  task automatic model_advance();
    int dv, du;
    case (m_mode)
      0: if (req != 2'b00) begin
        if (req == 2'b11) begin
`ifdef CLK_DIV_ARB_ROUND_ROBIN_EN
          m_win = (m_ptr == 0) ? 1 : 0;
`else
          m_win = 0;
`endif
        end else begin
          m_win = req[0] ? 0 : 1;
        end
        dv = (m_win == 1) ? int'(div1) : int'(div0);
        if (dv == 0) dv = 1;
        du = (m_win == 1) ? int'(dur1) : int'(dur0);
        m_h    = dv + 1;
        m_len  = 2 * du * m_h + 1;
        m_r    = 1;
        m_mode = 1;
        m_ptr  = m_win;
      end
      1: begin
        if (!req[m_win])        m_mode = 0;
        else if (m_r == m_len)  m_mode = 2;
        else                    m_r++;
      end
      default: m_mode = 0;
    endcase
  endtask

  // Apply inputs for one cycle, advance the model across the edge, then compare.
  task automatic step(input logic [1:0] r, input logic [8:0] a0, input logic [15:0] b0,
                      input logic [8:0] a1, input logic [15:0] b1);
    logic exp_clk;
    req = r; div0 = a0; dur0 = b0; div1 = a1; dur1 = b1;
    model_advance();
    @(posedge clk_20k);
    #1;
    exp_clk = (m_mode == 1) && (m_r >= 2) && ((((m_r - 2) / m_h) % 2) == 0);
    chk("gnt",     32'(gnt),     32'((m_mode != 0) ? onehot(m_win) : 2'b00));
    chk("done",    32'(done),    32'((m_mode == 2) ? onehot(m_win) : 2'b00));
    chk("busy",    32'(busy),    32'(m_mode != 0));
    chk("clk_out", 32'(clk_out), 32'(exp_clk));
  endtask

  task automatic run_until_done(input logic [1:0] mask_in, input logic [8:0] a0, input logic [15:0] b0,
                                input logic [8:0] a1, input logic [15:0] b1,
                                output int busy_n, output int high_n, output logic [1:0] first_g);
    logic [1:0] mask;
    bit fin;
    mask = mask_in; fin = 0; busy_n = 0; high_n = 0; first_g = '0;
    for (int k = 0; k < 400; k++) begin
      step(mask, a0, b0, a1, b1);
      if (busy) begin
        if (busy_n == 0) first_g = gnt;
        busy_n++;
      end
      if (clk_out) high_n++;
      mask = mask & ~done;
      if (mask == 2'b00 && !busy) begin
        fin = 1;
        break;
      end
    end
    chk("serve_finished", 32'(fin), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bn, hn;
    logic [1:0] fg;
    logic [1:0] exp_first;
    bit act [2];

    // Reset held with both requests asserted.
    req = 2'b11; div0 = 9'd3; dur0 = 16'd2;
    repeat (3) @(posedge clk_20k);
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_clk", 32'(clk_out), 32'd0);
    req = 2'b00;
    rst_n = 1'b1;
    model_reset();
    step(2'b00, 0, 0, 0, 0);

    // Single request: div 3, dur 2.
    run_until_done(2'b01, 9'd3, 16'd2, 9'd0, 16'd0, bn, hn, fg);
    $display("single: busy=%0d high=%0d gnt=%b", bn, hn, fg);
    chk("single_busy", 32'(bn), 32'd18);
    chk("single_high", 32'(hn), 32'd8);
    chk("single_gnt", 32'(fg), 32'd1);

    // Simultaneous requests.
`ifdef CLK_DIV_ARB_ROUND_ROBIN_EN
    exp_first = 2'b10;
`else
    exp_first = 2'b01;
`endif
    run_until_done(2'b11, 9'd1, 16'd1, 9'd2, 16'd1, bn, hn, fg);
    $display("simul: busy=%0d high=%0d first=%b", bn, hn, fg);
    chk("simul_first", 32'(fg), 32'(exp_first));
    chk("simul_busy", 32'(bn), 32'd14);
    chk("simul_high", 32'(hn), 32'd5);

    // Divisor 0 forced to 1.
    run_until_done(2'b01, 9'd0, 16'd1, 9'd0, 16'd0, bn, hn, fg);
    $display("div0: busy=%0d high=%0d", bn, hn);
    chk("div0_busy", 32'(bn), 32'd6);
    chk("div0_high", 32'(hn), 32'd2);

    // Zero duration.
    run_until_done(2'b01, 9'd5, 16'd0, 9'd0, 16'd0, bn, hn, fg);
    $display("dur0: busy=%0d high=%0d", bn, hn);
    chk("dur0_busy", 32'(bn), 32'd2);
    chk("dur0_high", 32'(hn), 32'd0);

    // Abort during RUN cycle 5 with requester 1 pending.
    step(2'b01, 9'd3, 16'd2, 9'd1, 16'd1);
    for (int k = 0; k < 4; k++) step(2'b11, 9'd3, 16'd2, 9'd1, 16'd1);
    step(2'b10, 9'd3, 16'd2, 9'd1, 16'd1);
    $display("abort: gnt=%b done=%b clk_out=%b", gnt, done, clk_out);
    chk("abort_gnt", 32'(gnt), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_clk", 32'(clk_out), 32'd0);
    step(2'b10, 9'd3, 16'd2, 9'd1, 16'd1);
    chk("after_abort_gnt", 32'(gnt), 32'd2);
    run_until_done(2'b10, 9'd3, 16'd2, 9'd1, 16'd1, bn, hn, fg);

    // Asynchronous reset while clk_out is high.
    for (int k = 0; k < 10; k++) begin
      step(2'b01, 9'd3, 16'd2, 9'd0, 16'd0);
      if (clk_out) break;
    end
    chk("arst_pre_clk", 32'(clk_out), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    $display("arst: gnt=%b done=%b busy=%b clk_out=%b", gnt, done, busy, clk_out);
    chk("arst_gnt", 32'(gnt), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_clk", 32'(clk_out), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    model_reset();
    req = 2'b00;
    @(posedge clk_20k);
    #1;
    rst_n = 1'b1;
    step(2'b00, 0, 0, 0, 0);

    // Randomized traffic with holds, completions and occasional aborts.
    act[0] = 0; act[1] = 0;
    for (int it = 0; it < 3000; it++) begin
      for (int i = 0; i < 2; i++) begin
        if (act[i] && done[i]) act[i] = 0;
        else if (act[i] && gnt[i] && $urandom_range(0, 59) == 0) act[i] = 0;
        if (!act[i] && $urandom_range(0, 7) == 0) act[i] = 1;
      end
      step({act[1], act[0]}, 9'($urandom_range(0, 4)), 16'($urandom_range(0, 3)),
           9'($urandom_range(0, 4)), 16'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
